// File: rtl/traffic_light_param_if.sv
// Controller <-> supervisor bundle: pedestrian request in, lamps/phase/count/cycle pulse out.
// The night request wire exists only when TL_NIGHT_MODE_EN is defined.
`timescale 1ns/1ps
interface traffic_light_param_if #(
  parameter int CNT_W = 12
);
  logic             pass;
`ifdef TL_NIGHT_MODE_EN
  logic             night;
`endif
  logic             R;
  logic             G;
  logic             Y;
  logic [2:0]       phase;
  logic [CNT_W-1:0] cnt;
  logic             cycle_done;

`ifdef TL_NIGHT_MODE_EN
  modport master (output pass, output night,
                  input R, input G, input Y, input phase, input cnt, input cycle_done);
  modport slave  (input pass, input night,
                  output R, output G, output Y, output phase, output cnt, output cycle_done);
`else
  modport master (output pass,
                  input R, input G, input Y, input phase, input cnt, input cycle_done);
  modport slave  (input pass,
                  output R, output G, output Y, output phase, output cnt, output cycle_done);
`endif
endinterface

// File: rtl/traffic_light_param.sv
// Single-approach light: GREEN, BLINK_N off/on green flashes, YELLOW, RED; pass restarts at GREEN.
// Moore outputs, zero latency from state. Optional flashing-yellow night mode via TL_NIGHT_MODE_EN.
`timescale 1ns/1ps
module traffic_light_param #(
  parameter int CNT_W     = 12,
  parameter int G_CYC     = 1024,
  parameter int BLINK_CYC = 128,
  parameter int BLINK_N   = 2,
  parameter int Y_CYC     = 512,
  parameter int R_CYC     = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_param_if.slave  bus
);

  typedef enum logic [2:0] {
    GREEN     = 3'd0,
    BOFF      = 3'd1,
    BON       = 3'd2,
    YELLOW    = 3'd3,
    RED       = 3'd4,
    NIGHT_OFF = 3'd5,
    NIGHT_ON  = 3'd6
  } state_t;

  localparam int PAIR_W = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;

  localparam logic [CNT_W-1:0]  G_LAST    = CNT_W'(G_CYC - 1);
  localparam logic [CNT_W-1:0]  B_LAST    = CNT_W'(BLINK_CYC - 1);
  localparam logic [CNT_W-1:0]  Y_LAST    = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0]  R_LAST    = CNT_W'(R_CYC - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'((BLINK_N > 0) ? BLINK_N - 1 : 0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PAIR_W-1:0]  pair, pair_nxt;
  logic [CNT_W-1:0]   dur_last;
  logic               is_day;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GREEN;
      cnt   <= '0;
      pair  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pair  <= pair_nxt;
    end
  end

  always_comb begin
    dur_last = B_LAST;
    case (state)
      GREEN:   dur_last = G_LAST;
      YELLOW:  dur_last = Y_LAST;
      RED:     dur_last = R_LAST;
      default: dur_last = B_LAST;
    endcase
  end

  assign is_day = (state <= RED);

  // Overrides are applied last so they win: night beats pass, pass beats expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    pair_nxt  = pair;
    if (cnt == dur_last) begin
      cnt_nxt = '0;
      case (state)
        GREEN:     state_nxt = (BLINK_N == 0) ? YELLOW : BOFF;
        BOFF:      state_nxt = BON;
        BON: begin
          pair_nxt  = pair + 1'b1;
          state_nxt = (pair == PAIR_LAST) ? YELLOW : BOFF;
        end
        YELLOW:    state_nxt = RED;
        RED: begin
          state_nxt = GREEN;
          pair_nxt  = '0;
        end
`ifdef TL_NIGHT_MODE_EN
        NIGHT_OFF: state_nxt = NIGHT_ON;
        NIGHT_ON:  state_nxt = NIGHT_OFF;
`endif
        default:   state_nxt = GREEN;
      endcase
    end
    if (bus.pass && is_day && state != GREEN) begin
      state_nxt = GREEN;
      cnt_nxt   = '0;
      pair_nxt  = '0;
    end
`ifdef TL_NIGHT_MODE_EN
    if (bus.night && is_day) begin
      state_nxt = NIGHT_OFF;
      cnt_nxt   = '0;
      pair_nxt  = '0;
    end else if (!bus.night && !is_day) begin
      // Leaving night always grants a full red before traffic resumes.
      state_nxt = RED;
      cnt_nxt   = '0;
      pair_nxt  = '0;
    end
`endif
  end

  always_comb begin
    bus.R          = 1'b0;
    bus.G          = 1'b0;
    bus.Y          = 1'b0;
    bus.phase      = state;
    bus.cnt        = cnt;
    bus.cycle_done = (state == RED) && (cnt == R_LAST);
    case (state)
      GREEN, BON: bus.G = 1'b1;
      YELLOW:     bus.Y = 1'b1;
      RED:        bus.R = 1'b1;
`ifdef TL_NIGHT_MODE_EN
      NIGHT_ON:   bus.Y = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_param.sv
// Bench for traffic_light_param: default-parameter and short-parameter instances checked each cycle
// against a position-in-cycle reference model, plus checkpoint tables and hand-written corner sequences.
`timescale 1ns/1ps
module tb_traffic_light_param;

  localparam int AG = 1024, ABC = 128, ABN = 2, AY = 512, AR = 1024;
  localparam int BG = 4,    BBC = 2,   BBN = 0, BY = 3,   BR = 5;

  logic clk;
  logic rst;

  traffic_light_param_if #(.CNT_W(12)) ifa ();
  traffic_light_param_if #(.CNT_W(3))  ifb ();

  traffic_light_param #(.CNT_W(12), .G_CYC(AG), .BLINK_CYC(ABC), .BLINK_N(ABN), .Y_CYC(AY), .R_CYC(AR))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  traffic_light_param #(.CNT_W(3), .G_CYC(BG), .BLINK_CYC(BBC), .BLINK_N(BBN), .Y_CYC(BY), .R_CYC(BR))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    int         cnt;
    logic       done;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] rgy;
    logic [2:0] ph;
    int         cnt;
    logic       done;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   ta, tb_t;
  bit   a_night = 1'b0;
  vec_t va[16];
  vec_t vb[13];

  // t = cycles elapsed since the current day cycle began with GREEN cnt=0.
  function automatic exp_t model(input int t, input int g, input int bc, input int bn,
                                 input int y, input int r);
    exp_t e;
    int   u;
    e.done = 1'b0;
    if (t < g) begin
      e.ph = 0; e.cnt = t;
    end else begin
      u = t - g;
      if (u < 2 * bn * bc) begin
        e.ph  = ((u / bc) % 2 == 0) ? 1 : 2;
        e.cnt = u % bc;
      end else begin
        u = u - 2 * bn * bc;
        if (u < y) begin
          e.ph = 3; e.cnt = u;
        end else begin
          e.ph = 4; e.cnt = u - y; e.done = (u - y == r - 1);
        end
      end
    end
    return e;
  endfunction

  function automatic int next_t(input int t, input bit p, input int g, input int bc,
                                input int bn, input int y, input int r);
    if (p && t >= g) return 0;
    return (t + 1) % (g + 2 * bn * bc + y + r);
  endfunction

  function automatic logic [2:0] lamps(input int ph);
    case (ph)
      0, 2:    return 3'b010;
      3, 6:    return 3'b001;
      4:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic check_a();
    exp_t e;
    e = model(ta, AG, ABC, ABN, AY, AR);
    chk("a_lamps", 32'({ifa.R, ifa.G, ifa.Y}), 32'(lamps(e.ph)));
    chk("a_phase", 32'(ifa.phase), 32'(e.ph));
    chk("a_cnt",   32'(ifa.cnt), 32'(e.cnt));
    chk("a_done",  32'(ifa.cycle_done), 32'(e.done));
  endtask

  task automatic check_b();
    exp_t e;
    e = model(tb_t, BG, BBC, BBN, BY, BR);
    chk("b_lamps", 32'({ifb.R, ifb.G, ifb.Y}), 32'(lamps(e.ph)));
    chk("b_phase", 32'(ifb.phase), 32'(e.ph));
    chk("b_cnt",   32'(ifb.cnt), 32'(e.cnt));
    chk("b_done",  32'(ifb.cycle_done), 32'(e.done));
  endtask

  // Called at a negedge: drive pass for the coming edge, advance one cycle, check.
  task automatic tick(input bit pa, input bit pb);
    ifa.pass = pa;
    ifb.pass = pb;
    @(negedge clk);
    if (!a_night) ta = next_t(ta, pa, AG, ABC, ABN, AY, AR);
    tb_t = next_t(tb_t, pb, BG, BBC, BBN, BY, BR);
    if (!a_night) check_a();
    check_b();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0]  = '{0,    3'b010, 3'd0, 0,    1'b0};
    va[1]  = '{1023, 3'b010, 3'd0, 1023, 1'b0};
    va[2]  = '{1024, 3'b000, 3'd1, 0,    1'b0};
    va[3]  = '{1151, 3'b000, 3'd1, 127,  1'b0};
    va[4]  = '{1152, 3'b010, 3'd2, 0,    1'b0};
    va[5]  = '{1279, 3'b010, 3'd2, 127,  1'b0};
    va[6]  = '{1280, 3'b000, 3'd1, 0,    1'b0};
    va[7]  = '{1407, 3'b000, 3'd1, 127,  1'b0};
    va[8]  = '{1408, 3'b010, 3'd2, 0,    1'b0};
    va[9]  = '{1535, 3'b010, 3'd2, 127,  1'b0};
    va[10] = '{1536, 3'b001, 3'd3, 0,    1'b0};
    va[11] = '{2047, 3'b001, 3'd3, 511,  1'b0};
    va[12] = '{2048, 3'b100, 3'd4, 0,    1'b0};
    va[13] = '{3070, 3'b100, 3'd4, 1022, 1'b0};
    va[14] = '{3071, 3'b100, 3'd4, 1023, 1'b1};
    va[15] = '{3072, 3'b010, 3'd0, 0,    1'b0};

    vb[0]  = '{0,  3'b010, 3'd0, 0, 1'b0};
    vb[1]  = '{1,  3'b010, 3'd0, 1, 1'b0};
    vb[2]  = '{2,  3'b010, 3'd0, 2, 1'b0};
    vb[3]  = '{3,  3'b010, 3'd0, 3, 1'b0};
    vb[4]  = '{4,  3'b001, 3'd3, 0, 1'b0};
    vb[5]  = '{5,  3'b001, 3'd3, 1, 1'b0};
    vb[6]  = '{6,  3'b001, 3'd3, 2, 1'b0};
    vb[7]  = '{7,  3'b100, 3'd4, 0, 1'b0};
    vb[8]  = '{8,  3'b100, 3'd4, 1, 1'b0};
    vb[9]  = '{9,  3'b100, 3'd4, 2, 1'b0};
    vb[10] = '{10, 3'b100, 3'd4, 3, 1'b0};
    vb[11] = '{11, 3'b100, 3'd4, 4, 1'b1};
    vb[12] = '{12, 3'b010, 3'd0, 0, 1'b0};

    rst = 1'b1;
    ifa.pass = 1'b0;
    ifb.pass = 1'b0;
`ifdef TL_NIGHT_MODE_EN
    ifa.night = 1'b0;
    ifb.night = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_g", 32'({ifa.R, ifa.G, ifa.Y, ifa.cycle_done}), 32'(4'b0100));
    rst  = 1'b0;
    ta   = 0;
    tb_t = 0;
    check_a();
    check_b();

    // Undisturbed full cycle with checkpoint tables.
    for (int c = 0; c <= 3072; c++) begin
      foreach (va[k]) if (va[k].cyc == c) begin
        chk("tbl_a_rgy",  32'({ifa.R, ifa.G, ifa.Y}), 32'(va[k].rgy));
        chk("tbl_a_ph",   32'(ifa.phase), 32'(va[k].ph));
        chk("tbl_a_cnt",  32'(ifa.cnt), 32'(va[k].cnt));
        chk("tbl_a_done", 32'(ifa.cycle_done), 32'(va[k].done));
      end
      foreach (vb[k]) if (vb[k].cyc == c) begin
        chk("tbl_b_rgy",  32'({ifb.R, ifb.G, ifb.Y}), 32'(vb[k].rgy));
        chk("tbl_b_ph",   32'(ifb.phase), 32'(vb[k].ph));
        chk("tbl_b_cnt",  32'(ifb.cnt), 32'(vb[k].cnt));
        chk("tbl_b_done", 32'(ifb.cycle_done), 32'(vb[k].done));
      end
      if (c < 3072) tick(1'b0, 1'b0);
    end

    // pass in GREEN ignored; pass in YELLOW restarts GREEN.
    for (int r = 0; r < 1700; r++) begin
      tick(r == 500, 1'($urandom_range(0, 7) == 0));
      if (r == 1023) chk("boff_after_green_pass", 32'(ifa.phase), 32'd1);
    end
    chk("yellow_before_pass", 32'(ifa.phase), 32'd3);
    tick(1'b1, 1'b0);
    chk("pass_in_yellow", 32'({ifa.G, 12'(ifa.cnt)}), 32'({1'b1, 12'd0}));
    for (int r = 0; r < 1023; r++) tick(1'b0, 1'($urandom_range(0, 7) == 0));
    chk("green_full_after_pass", 32'({ifa.G, 12'(ifa.cnt)}), 32'({1'b1, 12'd1023}));

    // pass coinciding with the last RED cycle.
    while (ta != 3071) tick(1'b0, 1'($urandom_range(0, 7) == 0));
    chk("done_on_last_red", 32'(ifa.cycle_done), 32'd1);
    tick(1'b1, 1'b0);
    chk("pass_at_wrap", 32'({ifa.phase, 12'(ifa.cnt)}), 32'({3'd0, 12'd0}));

    // Random pass pulses on both instances.
    for (int i = 0; i < 4000; i++)
      tick(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 7) == 0));

    // Asynchronous reset mid-RED at cnt=300.
    for (int i = 0; i < 4000 && ta != 2348; i++) tick(1'b0, 1'($urandom_range(0, 7) == 0));
    chk("reached_red_300", 32'(ta), 32'd2348);
    chk("red_before_rst", 32'({ifa.R, 12'(ifa.cnt)}), 32'({1'b1, 12'd300}));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", 32'({ifa.R, ifa.G, ifa.Y, ifa.phase, 12'(ifa.cnt), ifa.cycle_done}),
        32'({3'b010, 3'd0, 12'd0, 1'b0}));
    chk("async_rst_b", 32'({ifb.G, ifb.phase, 3'(ifb.cnt)}), 32'({1'b1, 3'd0, 3'd0}));
    @(negedge clk);
    chk("rst_held", 32'({ifa.G, 12'(ifa.cnt)}), 32'({1'b1, 12'd0}));
    rst  = 1'b0;
    ta   = 0;
    tb_t = 0;
    check_a();
    check_b();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'($urandom_range(0, 7) == 0));

`ifdef TL_NIGHT_MODE_EN
    a_night   = 1'b1;
    ifa.night = 1'b1;
    tick(1'b0, 1'b0);
    for (int i = 0; i < 384; i++) begin
      chk("night_lamps", 32'({ifa.R, ifa.G, ifa.Y}), 32'({2'b00, 1'(((i / ABC) % 2) == 1)}));
      chk("night_phase", 32'(ifa.phase), 32'((((i / ABC) % 2) == 1) ? 6 : 5));
      chk("night_cnt", 32'(ifa.cnt), 32'(i % ABC));
      if (i == 383) ifa.night = 1'b0;
      tick(1'(i != 383 && $urandom_range(0, 3) == 0), 1'b0);
    end
    a_night = 1'b0;
    ta      = AG + 2 * ABN * ABC + AY;
    check_a();
    for (int i = 0; i < 1030; i++) tick(1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
